// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI frame decoder and its register bus.
//   - dec_state_t    : decoder state encoding (IDLE, RD_ISSUE, RD_CAPTURE, WAIT_DATA)
//   - CMD_*          : bit positions inside the command byte
//   - ADDR_W_DEFAULT : default register address width
package spi_regs_pkg;

  localparam int ADDR_W_DEFAULT = 6;

  // Command byte layout: [7] 1=write/0=read, [6] upper/lower half, [5:0] address
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_HI_BIT   = 6;
  localparam int CMD_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2,
    WAIT_DATA  = 2'd3
  } dec_state_t;

endpackage

// File: rtl/spi_instr_decoder.sv
// Frame-level controller between the SPI byte bridge and the PWM register file.
// Each frame carries a command byte (R/W, hi/lo half, address) followed by a
// data byte. Writes produce a one-cycle reg_write strobe after the data byte;
// reads produce a one-cycle reg_read strobe after the command byte and the
// returned data is registered onto data_out for shift-out during byte two.
//
// Optional build macro: SPI_BURST_AUTOINC_EN
//   When defined, a frame keeps its transaction type after each data byte and
//   steps {reg_addr, reg_hi} by one (lo then hi of each register, wrapping),
//   until frame_active falls.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_active        synchronised chip-select (high = frame in progress)
//   byte_sync, data_in  one-cycle pulse with a received byte
//   data_out            byte the bridge shifts out on MISO
//   reg_addr, reg_hi    register address and half select
//   reg_write, reg_wdata  write strobe and data
//   reg_read, reg_rdata   read strobe and data (valid one cycle after reg_read)
//   busy                high between a command byte and transaction completion
module spi_instr_decoder
  import spi_regs_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_hi,
  output logic              reg_write,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_read,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  dec_state_t          state_reg, state_next;
  logic                is_write_reg;
  logic [ADDR_W-1:0]   reg_addr_reg;
  logic                reg_hi_reg;
  logic [DATA_W-1:0]   data_out_reg;
  logic [DATA_W-1:0]   reg_wdata_reg;
  logic                reg_write_reg;
  logic                busy_reg;

  logic                latch_cmd;
  logic                do_write;
  logic                capture;
`ifdef SPI_BURST_AUTOINC_EN
  logic                inc_addr;
`endif

  always_comb begin
    state_next = state_reg;
    latch_cmd  = 1'b0;
    do_write   = 1'b0;
    capture    = 1'b0;
`ifdef SPI_BURST_AUTOINC_EN
    inc_addr   = 1'b0;
`endif
    if (state_reg != IDLE && !frame_active) begin
      // Frame abort: drop back to IDLE, no capture, no pending write.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (byte_sync && frame_active) begin
            latch_cmd  = 1'b1;
            state_next = data_in[CMD_RW_BIT] ? WAIT_DATA : RD_ISSUE;
          end
        end
        // Any byte_sync seen in the two read states is dropped.
        RD_ISSUE:   state_next = RD_CAPTURE;
        RD_CAPTURE: begin
          capture    = 1'b1;
          state_next = WAIT_DATA;
        end
        WAIT_DATA: begin
          if (byte_sync) begin
            do_write = is_write_reg;
`ifdef SPI_BURST_AUTOINC_EN
            // Writes step the address after their strobe (see below) so the
            // address stays stable while reg_write is high; reads step now.
            inc_addr   = !is_write_reg;
            state_next = is_write_reg ? WAIT_DATA : RD_ISSUE;
`else
            state_next = IDLE;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
`ifdef SPI_BURST_AUTOINC_EN
    if (reg_write_reg) begin
      inc_addr = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      is_write_reg  <= 1'b0;
      reg_addr_reg  <= '0;
      reg_hi_reg    <= 1'b0;
      data_out_reg  <= '0;
      reg_wdata_reg <= '0;
      reg_write_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      reg_write_reg <= do_write;
      busy_reg      <= (state_next != IDLE);
      if (latch_cmd) begin
        is_write_reg <= data_in[CMD_RW_BIT];
        reg_hi_reg   <= data_in[CMD_HI_BIT];
        reg_addr_reg <= data_in[CMD_ADDR_LSB +: ADDR_W];
      end
`ifdef SPI_BURST_AUTOINC_EN
      else if (inc_addr) begin
        {reg_addr_reg, reg_hi_reg} <= {reg_addr_reg, reg_hi_reg} + {{ADDR_W{1'b0}}, 1'b1};
      end
`endif
      if (capture) begin
        data_out_reg <= reg_rdata;
      end
      if (do_write) begin
        reg_wdata_reg <= data_in;
      end
    end
  end

  assign reg_read  = (state_reg == RD_ISSUE);
  assign reg_write = reg_write_reg;
  assign reg_wdata = reg_wdata_reg;
  assign reg_addr  = reg_addr_reg;
  assign reg_hi    = reg_hi_reg;
  assign data_out  = data_out_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_spi_instr_decoder.sv
// Self-checking bench for spi_instr_decoder: table-driven frames plus
// hand-written abort / reset / protocol-violation / burst sequences.
// Expected register-bus strobes are queued when bytes are driven and matched
// by a monitor when the DUT raises reg_read or reg_write.
module tb_spi_instr_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_active = 1'b0;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [5:0] reg_addr;
  logic       reg_hi;
  logic       reg_write;
  logic [7:0] reg_wdata;
  logic       reg_read;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  always #5 clk = ~clk;

  spi_instr_decoder #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_active (frame_active),
    .byte_sync    (byte_sync),
    .data_in      (data_in),
    .data_out     (data_out),
    .reg_addr     (reg_addr),
    .reg_hi       (reg_hi),
    .reg_write    (reg_write),
    .reg_wdata    (reg_wdata),
    .reg_read     (reg_read),
    .reg_rdata    (reg_rdata),
    .busy         (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register file model: data returned one cycle after reg_read, 0 otherwise.
  logic [7:0] mem [128];
  always @(posedge clk) reg_rdata <= reg_read ? mem[{reg_addr, reg_hi}] : 8'h00;

  int unsigned cyc = 0;
  int unsigned last_sync = 0;
  always @(posedge clk) begin
    if (byte_sync && frame_active) last_sync <= cyc;
    cyc <= cyc + 1;
  end

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    logic       hi;
    logic [7:0] data;
  } strobe_t;
  strobe_t sb_q[$];
  strobe_t mon_e;

  task automatic push_write(input logic [5:0] a, input logic h, input logic [7:0] d);
    strobe_t e;
    e.wr = 1'b1; e.addr = a; e.hi = h; e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic push_read(input logic [5:0] a, input logic h);
    strobe_t e;
    e.wr = 1'b0; e.addr = a; e.hi = h; e.data = 8'h00;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (reg_read || reg_write)) begin
      check("rd_wr_exclusive", {15'd0, reg_read & reg_write}, 16'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual wr=%0d rd=%0d addr=%0d hi=%0d required none",
                 reg_write, reg_read, reg_addr, reg_hi);
      end else begin
        mon_e = sb_q.pop_front();
        check("strobe_is_write", {15'd0, reg_write}, {15'd0, mon_e.wr});
        check("strobe_addr", {10'd0, reg_addr}, {10'd0, mon_e.addr});
        check("strobe_hi", {15'd0, reg_hi}, {15'd0, mon_e.hi});
        if (mon_e.wr) check("strobe_wdata", {8'd0, reg_wdata}, {8'd0, mon_e.data});
        check("strobe_latency", 16'(cyc - last_sync), 16'd1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge that samples the byte.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    data_in   = b;
    byte_sync = 1'b1;
    @(posedge clk);
    #1;
    byte_sync = 1'b0;
  endtask

  task automatic end_frame();
    frame_active = 1'b0;
    idle(2);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    bit         exp_wr;
    logic [5:0] exp_addr;
    logic       exp_hi;
    logic [7:0] exp_byte;  // reg_wdata for writes, data_out for reads
  } vec_t;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] key;
    logic [6:0] end_key;
    logic [7:0] end_dout;

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom_range(0, 255));

    vecs[0] = '{8'h85, 8'h3C, 1'b1, 6'd5,  1'b0, 8'h3C};
    vecs[1] = '{8'h4A, 8'h00, 1'b0, 6'd10, 1'b1, 8'hA7};
    vecs[2] = '{8'hC0, 8'hFF, 1'b1, 6'd0,  1'b1, 8'hFF};
    vecs[3] = '{8'h3F, 8'h55, 1'b0, 6'd63, 1'b0, 8'h5C};
    vecs[4] = '{8'hFE, 8'h81, 1'b1, 6'd62, 1'b1, 8'h81};
    vecs[5] = '{8'h01, 8'hAA, 1'b0, 6'd1,  1'b0, 8'h3E};

    // Reset state
    idle(2);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_reg_write", {15'd0, reg_write}, 16'd0);
    check("rst_reg_read", {15'd0, reg_read}, 16'd0);
    check("rst_reg_addr", {10'd0, reg_addr}, 16'd0);
    check("rst_reg_hi", {15'd0, reg_hi}, 16'd0);
    check("rst_data_out", {8'd0, data_out}, 16'd0);
    check("rst_reg_wdata", {8'd0, reg_wdata}, 16'd0);
    rst_n = 1'b1;
    idle(2);

    // Table-driven single-transaction frames
    for (int i = 0; i < 6; i++) begin
      key = {vecs[i].exp_addr, vecs[i].exp_hi};
      end_key = key;
      end_dout = vecs[i].exp_byte;
      if (vecs[i].exp_wr) begin
        push_write(vecs[i].exp_addr, vecs[i].exp_hi, vecs[i].dat);
`ifdef SPI_BURST_AUTOINC_EN
        end_key = key + 7'd1;
`endif
      end else begin
        mem[key] = vecs[i].exp_byte;
        push_read(vecs[i].exp_addr, vecs[i].exp_hi);
`ifdef SPI_BURST_AUTOINC_EN
        // The dummy byte triggers another read at the next half-register.
        end_key = key + 7'd1;
        push_read(end_key[6:1], end_key[0]);
        end_dout = mem[end_key];
`endif
      end
      frame_active = 1'b1;
      idle(2);
      send_byte(vecs[i].cmd);
      check("cmd_busy", {15'd0, busy}, 16'd1);
      if (!vecs[i].exp_wr) begin
        idle(2);  // data_out is due three cycles after the command sync
        check("rd_data_out_n3", {8'd0, data_out}, {8'd0, vecs[i].exp_byte});
      end
      idle(6);
      send_byte(vecs[i].dat);
`ifdef SPI_BURST_AUTOINC_EN
      check("data_busy", {15'd0, busy}, 16'd1);
`else
      check("data_busy", {15'd0, busy}, 16'd0);
`endif
      idle(3);
      end_frame();
      check("end_busy", {15'd0, busy}, 16'd0);
      check("end_reg_addr", {10'd0, reg_addr}, {10'd0, end_key[6:1]});
      check("end_reg_hi", {15'd0, reg_hi}, {15'd0, end_key[0]});
      if (vecs[i].exp_wr) check("end_reg_wdata", {8'd0, reg_wdata}, {8'd0, vecs[i].exp_byte});
      else                check("end_data_out", {8'd0, data_out}, {8'd0, end_dout});
      idle(2);
    end

    // Abort before the data byte: no write, busy drops the next cycle
    frame_active = 1'b1;
    idle(2);
    send_byte(8'h81);
    idle(3);
    check("abort_busy_before", {15'd0, busy}, 16'd1);
    frame_active = 1'b0;
    idle(1);
    check("abort_busy_after", {15'd0, busy}, 16'd0);
    idle(3);
    push_write(6'd2, 1'b0, 8'h11);
    frame_active = 1'b1;
    idle(2);
    send_byte(8'h82);
    idle(6);
    send_byte(8'h11);
    idle(3);
    end_frame();
    check("post_abort_wdata", {8'd0, reg_wdata}, 16'h0011);
    idle(2);

    // Asynchronous reset while waiting for write data
    frame_active = 1'b1;
    idle(2);
    send_byte(8'h85);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {15'd0, busy}, 16'd0);
    check("arst_reg_write", {15'd0, reg_write}, 16'd0);
    check("arst_reg_addr", {10'd0, reg_addr}, 16'd0);
    check("arst_data_out", {8'd0, data_out}, 16'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    // Next byte in the still-open frame must be decoded as a command
    mem[{6'd3, 1'b1}] = 8'h5A;
    push_read(6'd3, 1'b1);
    send_byte(8'h43);
    idle(6);
    check("post_rst_busy", {15'd0, busy}, 16'd1);
    check("post_rst_data_out", {8'd0, data_out}, 16'h005A);
    end_frame();
    check("post_rst_end_busy", {15'd0, busy}, 16'd0);
    idle(2);

    // Byte during RD_CAPTURE is dropped: machine still waits for a data byte
    mem[{6'd7, 1'b0}] = 8'h6D;
    push_read(6'd7, 1'b0);
    frame_active = 1'b1;
    idle(2);
    send_byte(8'h07);
    send_byte(8'h99);
    idle(4);
    check("viol_busy", {15'd0, busy}, 16'd1);
    check("viol_data_out", {8'd0, data_out}, 16'h006D);
    end_frame();
    check("viol_end_busy", {15'd0, busy}, 16'd0);
    idle(2);

`ifdef SPI_BURST_AUTOINC_EN
    // Burst write with auto-increment
    push_write(6'd3, 1'b0, 8'h01);
    push_write(6'd3, 1'b1, 8'h02);
    push_write(6'd4, 1'b0, 8'h03);
    frame_active = 1'b1;
    idle(2);
    send_byte(8'h83);
    idle(6);
    send_byte(8'h01);
    idle(8);
    send_byte(8'h02);
    idle(8);
    send_byte(8'h03);
    idle(4);
    check("burst_busy", {15'd0, busy}, 16'd1);
    end_frame();
    check("burst_end_busy", {15'd0, busy}, 16'd0);
    idle(2);

    // Address wraps from (63, hi) to (0, lo)
    push_write(6'd63, 1'b1, 8'hAA);
    push_write(6'd0, 1'b0, 8'hBB);
    frame_active = 1'b1;
    idle(2);
    send_byte(8'hFF);
    idle(6);
    send_byte(8'hAA);
    idle(8);
    send_byte(8'hBB);
    idle(4);
    end_frame();
    check("wrap_end_busy", {15'd0, busy}, 16'd0);
    idle(2);
`else
    // Without burst, a third byte in the frame is a fresh command
    mem[{6'd6, 1'b1}] = 8'hC3;
    push_write(6'd5, 1'b0, 8'h3C);
    push_read(6'd6, 1'b1);
    frame_active = 1'b1;
    idle(2);
    send_byte(8'h85);
    idle(6);
    send_byte(8'h3C);
    idle(6);
    send_byte(8'h46);
    idle(6);
    check("second_cmd_data_out", {8'd0, data_out}, 16'h00C3);
    send_byte(8'h00);
    idle(3);
    end_frame();
    check("second_cmd_reg_addr", {10'd0, reg_addr}, 16'd6);
    idle(2);
`endif

    check("scoreboard_empty", 16'(sb_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
